serial_compare_ctrl: RTL and testbench

SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

---
 rtl/cmp_pkg.sv | 13 +
 rtl/bit_compare_cell.sv | 16 +
 rtl/serial_compare_ctrl.sv | 114 +++++++++++
 tb/tb_serial_compare_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the bit-serial comparator: controller state encoding
// and the default operand width.
package cmp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cmp_state_t;

endpackage

// File: rtl/bit_compare_cell.sv
// Single-bit magnitude compare cell: relates one bit of A to one bit of B.
module bit_compare_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic neq,
    output logic gt,
    output logic lt
);

    assign neq = a ^ b;
    assign eq  = ~neq;
    assign gt  = a & ~b;
    assign lt  = ~a & b;

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned comparator, MSB first, one bit per cycle, stopping at the
// first differing bit. Handshake: start is taken only in IDLE; done pulses for
// one cycle with eq/gt/lt valid, and those flags hold until the next done.
module serial_compare_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);

    cmp_state_t       state, state_n;
    logic [WIDTH-1:0] a_sr, a_sr_n;
    logic [WIDTH-1:0] b_sr, b_sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             eq_r, eq_n;
    logic             gt_r, gt_n;
    logic             lt_r, lt_n;

    logic cell_eq, cell_neq, cell_gt, cell_lt;

    bit_compare_cell u_cell (
        .a   (a_sr[WIDTH-1]),
        .b   (b_sr[WIDTH-1]),
        .eq  (cell_eq),
        .neq (cell_neq),
        .gt  (cell_gt),
        .lt  (cell_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            cnt   <= '0;
            eq_r  <= 1'b0;
            gt_r  <= 1'b0;
            lt_r  <= 1'b0;
        end else begin
            state <= state_n;
            a_sr  <= a_sr_n;
            b_sr  <= b_sr_n;
            cnt   <= cnt_n;
            eq_r  <= eq_n;
            gt_r  <= gt_n;
            lt_r  <= lt_n;
        end
    end

    always_comb begin
        state_n = state;
        a_sr_n  = a_sr;
        b_sr_n  = b_sr;
        cnt_n   = cnt;
        eq_n    = eq_r;
        gt_n    = gt_r;
        lt_n    = lt_r;
        case (state)
            IDLE: begin
                if (start) begin
                    a_sr_n  = a_in;
                    b_sr_n  = b_in;
                    cnt_n   = CW'(WIDTH - 1);
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // Result flags are written only on the transition into DONE.
                if (cell_neq) begin
                    gt_n    = cell_gt;
                    lt_n    = cell_lt;
                    eq_n    = 1'b0;
                    state_n = DONE;
                end else if (cnt != '0) begin
                    a_sr_n = {a_sr[WIDTH-2:0], 1'b0};
                    b_sr_n = {b_sr[WIDTH-2:0], 1'b0};
                    cnt_n  = cnt - CW'(1);
                end else begin
                    eq_n    = cell_eq;
                    gt_n    = 1'b0;
                    lt_n    = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign eq        = eq_r;
    assign gt        = gt_r;
    assign lt        = lt_r;
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Testbench for serial_compare_ctrl (WIDTH=8): directed scenarios plus random
// traffic, checked cycle by cycle against a transaction-level reference model.
module tb_serial_compare_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy, done, eq, gt, lt;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase within the current comparison (0 = idle),
    // total latency of that comparison, and the pending/visible results.
    int   ph   = 0;
    int   lat  = 0;
    logic p_eq, p_gt, p_lt;
    logic m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;
    logic accepted;
    int   done_cnt;

    serial_compare_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Latency from the accept edge: first differing bit at MSB position k
    // gives k+2 cycles, equal operands give W+1.
    function automatic int calc_latency(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        for (int k = 0; k < W; k++) begin
            if (d[W-1-k]) return k + 2;
        end
        return W + 1;
    endfunction

    task automatic tick();
        accepted = 1'b0;
        if (rst) begin
            ph   = 0;
            m_eq = 1'b0;
            m_gt = 1'b0;
            m_lt = 1'b0;
        end else if (ph == 0) begin
            if (start) begin
                ph       = 1;
                lat      = calc_latency(a_in, b_in);
                p_eq     = (a_in == b_in);
                p_gt     = (a_in > b_in);
                p_lt     = (a_in < b_in);
                accepted = 1'b1;
            end
        end else if (ph == lat) begin
            ph = 0;
        end else begin
            ph++;
        end
        if (ph != 0 && ph == lat) begin
            m_eq = p_eq;
            m_gt = p_gt;
            m_lt = p_lt;
        end
        @(posedge clk);
        #1;
        check("busy", 32'(busy), 32'(ph != 0));
        check("done", 32'(done), 32'(ph != 0 && ph == lat));
        check("eq", 32'(eq), 32'(m_eq));
        check("gt", 32'(gt), 32'(m_gt));
        check("lt", 32'(lt), 32'(m_lt));
        check("idle_state", 32'(state_dbg == 2'd0), 32'(ph == 0));
        if (done) done_cnt++;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        a_in     = '0;
        b_in     = '0;
        done_cnt = 0;

        // Reset held two cycles with start high, then one quiet cycle.
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        tick();

        // MSB mismatch.
        launch(8'h80, 8'h7F);
        repeat (4) tick();

        // Equal operands.
        launch(8'hA5, 8'hA5);
        repeat (11) tick();

        // LSB mismatch; a start pulse and operand change mid-run are ignored.
        launch(8'h10, 8'h11);
        tick(); tick(); tick();
        a_in  = 8'hFF;
        b_in  = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();

        // Reset in the middle of a comparison, then a fresh one.
        launch(8'h3C, 8'h3C);
        tick(); tick(); tick();
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        launch(8'h01, 8'h02);
        repeat (10) tick();

        // Back-to-back with start held high and alternating operands.
        done_cnt = 0;
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (accepted) begin
                a_in = ~a_in;
                b_in = ~b_in;
            end
        end
        check("b2b_done_count", 32'(done_cnt), 32'd4);
        start = 1'b0;
        repeat (4) tick();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 2) != 0);
            a_in  = W'($urandom);
            case ($urandom_range(0, 2))
                0:       b_in = a_in;
                1:       b_in = a_in ^ (W'(1) << $urandom_range(0, W - 1));
                default: b_in = W'($urandom);
            endcase
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
